// File: rtl/multicycle_control_if.sv
// Unified memory port between the multi-cycle controller and memory:
// request qualifiers out, completion (ack) back.
interface multicycle_control_if;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output adr_src,
        output mem_size,
        output mem_unsigned,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  adr_src,
        input  mem_size,
        input  mem_unsigned,
        output mem_ack
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I controller: FETCH/DECODE/EXEC/MEM/WB sequencing over a shared
// ALU and one memory port, with illegal-opcode and memory-timeout traps.
module multicycle_control #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    multicycle_control_if.master mem,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic [2:0]       imm_src,
    output logic [1:0]       result_src,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWR  = 4'd4,
        S_WB_MEM = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_EXEC_U = 4'd8,
        S_WB_ALU = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_JALR   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_PASSB = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_U = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] CAUSE_ILL = 2'b01;
    localparam logic [1:0] CAUSE_MEM = 2'b10;

    state_t           st, st_nxt;
    logic             armed;
    logic [7:0]       wait_cnt, wait_nxt;
    logic             timed_out;
    logic             trap_q;
    logic [1:0]       cause_q, cause_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             taken;

    assign timed_out   = (wait_cnt == 8'(TIMEOUT));
    assign state       = st;
    assign trap        = trap_q;
    assign trap_cause  = cause_q;
    assign retired_cnt = cnt_q;

    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    // armed is low for exactly one cycle after reset so a handshake that reset
    // cut short is never re-requested in that same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st       <= S_FETCH;
            armed    <= 1'b0;
            wait_cnt <= '0;
            trap_q   <= 1'b0;
            cause_q  <= '0;
            cnt_q    <= '0;
        end else begin
            st       <= st_nxt;
            armed    <= 1'b1;
            wait_cnt <= wait_nxt;
            if (st_nxt == S_TRAP && st != S_TRAP) begin
                trap_q  <= 1'b1;
                cause_q <= cause_nxt;
            end
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        st_nxt           = st;
        wait_nxt         = '0;
        cause_nxt        = 2'b00;
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.adr_src      = 1'b0;
        mem.mem_size     = 2'b10;
        mem.mem_unsigned = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        pc_src           = 1'b0;
        reg_write        = 1'b0;
        alu_src_a        = 2'b00;
        alu_src_b        = 2'b00;
        alu_ctrl         = ALU_ADD;
        imm_src          = IMM_I;
        result_src       = 2'b00;
        retire           = 1'b0;

        case (st)
            S_FETCH: begin
                if (armed) begin
                    mem.mem_req = 1'b1;
                    alu_src_b   = 2'b10;
                    if (mem.mem_ack) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        st_nxt   = S_DECODE;
                    end else if (timed_out) begin
                        st_nxt    = S_TRAP;
                        cause_nxt = CAUSE_MEM;
                    end else begin
                        wait_nxt = wait_cnt + 8'd1;
                    end
                end
            end

            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: st_nxt = S_MEMADR;
                    OP_R:              st_nxt = S_EXEC_R;
                    OP_I:              st_nxt = S_EXEC_I;
                    OP_JAL:            st_nxt = S_JAL;
                    OP_JALR:           st_nxt = S_JALR;
                    OP_LUI, OP_AUIPC:  st_nxt = S_EXEC_U;
                    OP_BRANCH: begin
                        if (funct3[2:1] == 2'b01) begin
                            st_nxt    = S_TRAP;
                            cause_nxt = CAUSE_ILL;
                        end else begin
                            st_nxt = S_BRANCH;
                        end
                    end
                    default: begin
                        st_nxt    = S_TRAP;
                        cause_nxt = CAUSE_ILL;
                    end
                endcase
            end

            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = opcode[5] ? IMM_S : IMM_I;
                st_nxt    = opcode[5] ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                mem.mem_req      = 1'b1;
                mem.adr_src      = 1'b1;
                mem.mem_size     = funct3[1:0];
                mem.mem_unsigned = funct3[2];
                if (mem.mem_ack) begin
                    st_nxt = S_WB_MEM;
                end else if (timed_out) begin
                    st_nxt    = S_TRAP;
                    cause_nxt = CAUSE_MEM;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end

            S_MEMWR: begin
                mem.mem_req  = 1'b1;
                mem.mem_we   = 1'b1;
                mem.adr_src  = 1'b1;
                mem.mem_size = funct3[1:0];
                if (mem.mem_ack) begin
                    retire = 1'b1;
                    st_nxt = S_FETCH;
                end else if (timed_out) begin
                    st_nxt    = S_TRAP;
                    cause_nxt = CAUSE_MEM;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end

            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_ctrl  = {funct7b5, funct3};
                st_nxt    = S_WB_ALU;
            end

            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = IMM_I;
                // only the shift-right pair is distinguished by funct7b5 here
                alu_ctrl  = (funct3 == 3'b101) ? {funct7b5, funct3} : {1'b0, funct3};
                st_nxt    = S_WB_ALU;
            end

            S_EXEC_U: begin
                alu_src_b = 2'b01;
                imm_src   = IMM_U;
                if (opcode[5]) begin
                    alu_src_a = 2'b11;
                    alu_ctrl  = ALU_PASSB;
                end else begin
                    alu_src_a = 2'b01;
                    alu_ctrl  = ALU_ADD;
                end
                st_nxt = S_WB_ALU;
            end

            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = IMM_J;
                pc_write  = 1'b1;
                pc_src    = 1'b0;
                st_nxt    = S_WB_ALU;
            end

            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = IMM_I;
                pc_write  = 1'b1;
                pc_src    = 1'b0;
                st_nxt    = S_WB_ALU;
            end

            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_ctrl  = ALU_SUB;
                pc_src    = 1'b1;
                pc_write  = taken;
                retire    = 1'b1;
                st_nxt    = S_FETCH;
            end

            S_WB_ALU: begin
                reg_write  = 1'b1;
                result_src = 2'b00;
                retire     = 1'b1;
                st_nxt     = S_FETCH;
            end

            S_WB_MEM: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                retire     = 1'b1;
                st_nxt     = S_FETCH;
            end

            S_TRAP: st_nxt = S_TRAP;

            default: st_nxt = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its expected
// per-cycle output list, replayed against the DUT and compared every cycle.
module tb_multicycle_control;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct {
        bit       ack;
        bit       req, we, irw, pcw, rw, ret, trp;
        bit [1:0] cause;
        bit       c_adr;  bit       adr;
        bit       c_size; bit [1:0] size;
        bit       c_uns;  bit       uns;
        bit       c_alu;  bit [1:0] sa, sb; bit [3:0] op;
        bit       c_imm;  bit [2:0] imm;
        bit       c_pcs;  bit       pcs;
        bit       c_res;  bit [1:0] res;
        bit       c_lop;  bit [3:0] lop;
        bit       c_lcnt; bit [31:0] lcnt;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic funct7b5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0;
    logic ir_write, pc_write, pc_src, reg_write, retire, trap;
    logic [1:0] alu_src_a, alu_src_b, result_src, trap_cause;
    logic [3:0] alu_ctrl, state;
    logic [2:0] imm_src;
    logic [CW-1:0] retired_cnt;

    multicycle_control_if mif();

    multicycle_control #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .mem(mif.master),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .imm_src(imm_src), .result_src(result_src),
        .retire(retire), .retired_cnt(retired_cnt), .trap(trap),
        .trap_cause(trap_cause), .state(state)
    );

    always #5 clk = ~clk;

    cyc_t  q[$];
    cyc_t  cur;
    bit    cur_valid = 1'b0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    cnt_model = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cur_valid) begin
            chk("mem_req",     32'(mif.mem_req), 32'(cur.req));
            chk("mem_we",      32'(mif.mem_we),  32'(cur.we));
            chk("ir_write",    32'(ir_write),    32'(cur.irw));
            chk("pc_write",    32'(pc_write),    32'(cur.pcw));
            chk("reg_write",   32'(reg_write),   32'(cur.rw));
            chk("retire",      32'(retire),      32'(cur.ret));
            chk("trap",        32'(trap),        32'(cur.trp));
            chk("trap_cause",  32'(trap_cause),  32'(cur.cause));
            chk("retired_cnt", 32'(retired_cnt), 32'(cnt_model % (1 << CW)));
            if (cur.c_adr)  chk("adr_src",      32'(mif.adr_src),      32'(cur.adr));
            if (cur.c_size) chk("mem_size",     32'(mif.mem_size),     32'(cur.size));
            if (cur.c_uns)  chk("mem_unsigned", 32'(mif.mem_unsigned), 32'(cur.uns));
            if (cur.c_alu) begin
                chk("alu_src_a", 32'(alu_src_a), 32'(cur.sa));
                chk("alu_src_b", 32'(alu_src_b), 32'(cur.sb));
                chk("alu_ctrl",  32'(alu_ctrl),  32'(cur.op));
            end
            if (cur.c_imm)  chk("imm_src",      32'(imm_src),     32'(cur.imm));
            if (cur.c_pcs)  chk("pc_src",       32'(pc_src),      32'(cur.pcs));
            if (cur.c_res)  chk("result_src",   32'(result_src),  32'(cur.res));
            if (cur.c_lop)  chk("pin_alu_ctrl", 32'(alu_ctrl),    32'(cur.lop));
            if (cur.c_lcnt) chk("pin_retired",  32'(retired_cnt), cur.lcnt);
            if (cur.ret) cnt_model = cnt_model + 1;
        end
    end

    function automatic cyc_t blank();
        cyc_t c;
        c = '{default: 0};
        return c;
    endfunction

    function automatic cyc_t alu_c(bit [1:0] a, bit [1:0] b, bit [3:0] op, bit ci, bit [2:0] imm);
        cyc_t c;
        c = blank();
        c.c_alu = 1'b1; c.sa = a; c.sb = b; c.op = op;
        c.c_imm = ci;   c.imm = imm;
        return c;
    endfunction

    function automatic bit br_taken(bit [2:0] f3, bit z, bit l, bit lu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            3'd7: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_legal(bit [6:0] op);
        return op == OP_LOAD || op == OP_STORE || op == OP_R || op == OP_I ||
               op == OP_BRANCH || op == OP_JAL || op == OP_JALR ||
               op == OP_LUI || op == OP_AUIPC;
    endfunction

    task automatic trap_tail(bit [1:0] cause, int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = blank();
            c.trp = 1'b1; c.cause = cause;
            c.ack = 1'($urandom_range(0, 1));
            q.push_back(c);
        end
    endtask

    // dly = ack-low cycles before the ack; more than TO of them ends in a trap
    task automatic mem_wait(cyc_t w, cyc_t a, int dly, output bit trapped);
        trapped = 1'b0;
        for (int k = 0; k < dly && k <= int'(TO); k++) q.push_back(w);
        if (dly > int'(TO)) begin
            trapped = 1'b1;
            trap_tail(2'b10, 3);
        end else begin
            q.push_back(a);
        end
    endtask

    task automatic wb(bit [1:0] res);
        cyc_t c;
        c = blank();
        c.rw = 1'b1; c.ret = 1'b1; c.c_res = 1'b1; c.res = res;
        q.push_back(c);
    endtask

    task automatic build(int df, int dm, output bit trapped);
        cyc_t w, a, c;
        bit t;
        trapped = 1'b0;
        w = blank();
        w.req = 1'b1; w.c_adr = 1'b1; w.adr = 1'b0; w.c_size = 1'b1; w.size = 2'b10;
        a = w;
        a.ack = 1'b1; a.irw = 1'b1; a.pcw = 1'b1;
        a.c_alu = 1'b1; a.sa = 2'b00; a.sb = 2'b10; a.op = 4'b0000;
        a.c_pcs = 1'b1; a.pcs = 1'b0;
        mem_wait(w, a, df, t);
        if (t) begin
            trapped = 1'b1;
            return;
        end
        q.push_back(alu_c(2'b01, 2'b01, 4'b0000, 1'b1, 3'b011));
        case (opcode)
            OP_R: begin
                q.push_back(alu_c(2'b10, 2'b00, {funct7b5, funct3}, 1'b0, 3'b000));
                wb(2'b00);
            end
            OP_I: begin
                q.push_back(alu_c(2'b10, 2'b01,
                    (funct3 == 3'd5) ? {funct7b5, funct3} : {1'b0, funct3}, 1'b1, 3'b000));
                wb(2'b00);
            end
            OP_LUI: begin
                q.push_back(alu_c(2'b11, 2'b01, 4'b1001, 1'b1, 3'b001));
                wb(2'b00);
            end
            OP_AUIPC: begin
                q.push_back(alu_c(2'b01, 2'b01, 4'b0000, 1'b1, 3'b001));
                wb(2'b00);
            end
            OP_JAL, OP_JALR: begin
                if (opcode == OP_JAL) c = alu_c(2'b01, 2'b01, 4'b0000, 1'b1, 3'b100);
                else                  c = alu_c(2'b10, 2'b01, 4'b0000, 1'b1, 3'b000);
                c.pcw = 1'b1; c.c_pcs = 1'b1; c.pcs = 1'b0;
                q.push_back(c);
                wb(2'b00);
            end
            OP_BRANCH: begin
                if (funct3 == 3'd2 || funct3 == 3'd3) begin
                    trapped = 1'b1;
                    trap_tail(2'b01, 3);
                end else begin
                    c = alu_c(2'b10, 2'b00, 4'b1000, 1'b0, 3'b000);
                    c.c_pcs = 1'b1; c.pcs = 1'b1;
                    c.pcw = br_taken(funct3, zero, lt, ltu);
                    c.ret = 1'b1;
                    q.push_back(c);
                end
            end
            OP_LOAD: begin
                q.push_back(alu_c(2'b10, 2'b01, 4'b0000, 1'b1, 3'b000));
                w = blank();
                w.req = 1'b1; w.c_adr = 1'b1; w.adr = 1'b1;
                w.c_size = 1'b1; w.size = funct3[1:0];
                w.c_uns = 1'b1; w.uns = funct3[2];
                a = w; a.ack = 1'b1;
                mem_wait(w, a, dm, t);
                if (t) trapped = 1'b1;
                else   wb(2'b01);
            end
            OP_STORE: begin
                q.push_back(alu_c(2'b10, 2'b01, 4'b0000, 1'b1, 3'b010));
                w = blank();
                w.req = 1'b1; w.we = 1'b1; w.c_adr = 1'b1; w.adr = 1'b1;
                a = w; a.ack = 1'b1; a.ret = 1'b1;
                mem_wait(w, a, dm, t);
                if (t) trapped = 1'b1;
            end
            default: begin
                trapped = 1'b1;
                trap_tail(2'b01, 3);
            end
        endcase
    endtask

    task automatic play(int limit);
        int n;
        n = 0;
        while (q.size() > 0 && n < limit) begin
            cur = q.pop_front();
            mif.mem_ack = cur.ack;
            cur_valid = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        cur_valid = 1'b0;
        q.delete();
    endtask

    task automatic pin_op(int i, bit [3:0] v);
        cyc_t c;
        c = q[i]; c.c_lop = 1'b1; c.lop = v; q[i] = c;
    endtask

    task automatic pin_cnt(int i, bit [31:0] v);
        cyc_t c;
        c = q[i]; c.c_lcnt = 1'b1; c.lcnt = v; q[i] = c;
    endtask

    task automatic do_reset();
        cyc_t c;
        cur_valid = 1'b0;
        rst_n = 1'b0;
        mif.mem_ack = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt_model = 0;
        q.delete();
        c = blank();
        c.c_lcnt = 1'b1; c.lcnt = 0;
        q.push_back(c);
        play(10);
    endtask

    task automatic set_ir(bit [6:0] op, bit [2:0] f3, bit f7, bit z, bit l, bit lu);
        opcode = op; funct3 = f3; funct7b5 = f7; zero = z; lt = l; ltu = lu;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit tr;
        mif.mem_ack = 1'b0;
        do_reset();

        set_ir(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        build(0, 0, tr);
        chk("add_cycles", 32'(q.size()), 32'd4);
        pin_op(2, 4'b0000);
        pin_cnt(3, 0);
        play(100);

        set_ir(OP_LOAD, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        build(0, 3, tr);
        chk("lbu_cycles", 32'(q.size()), 32'd8);
        pin_cnt(0, 1);
        play(100);

        set_ir(OP_BRANCH, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        build(0, 0, tr);
        chk("bge_cycles", 32'(q.size()), 32'd3);
        play(100);
        set_ir(OP_BRANCH, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0);
        build(0, 0, tr);
        play(100);

        set_ir(OP_I, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0);
        build(0, 0, tr);
        pin_op(2, 4'b1101);
        play(100);
        set_ir(OP_I, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        build(0, 0, tr);
        pin_op(2, 4'b0000);
        play(100);

        set_ir(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        build(0, 0, tr);
        chk("sw_cycles", 32'(q.size()), 32'd4);
        play(100);
        set_ir(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        build(0, 0, tr);
        chk("jal_cycles", 32'(q.size()), 32'd4);
        play(100);
        set_ir(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        build(0, 0, tr);
        chk("lui_cycles", 32'(q.size()), 32'd4);
        pin_op(2, 4'b1001);
        pin_cnt(0, 8);
        play(100);

        set_ir(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        build(0, 0, tr);
        trap_tail(2'b01, 4);
        play(100);
        do_reset();

        set_ir(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        build(int'(TO) + 1, 0, tr);
        chk("timeout_cycles", 32'(q.size()), 32'(TO + 1 + 3));
        play(100);
        do_reset();
        build(int'(TO), 0, tr);
        chk("ack_at_limit_cycles", 32'(q.size()), 32'(TO + 4));
        play(100);

        set_ir(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        build(0, int'(TO) + 2, tr);
        play(100);
        do_reset();

        build(0, 3, tr);
        play(5);
        do_reset();

        for (int n = 0; n < 220; n++) begin
            int r, sub, df, dm;
            bit [6:0] op;
            bit [2:0] f3;
            r  = $urandom_range(0, 9);
            df = $urandom_range(0, TO);
            dm = $urandom_range(0, TO);
            f3 = 3'($urandom_range(0, 7));
            op = OP_R;
            case (r)
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LUI;
                3: op = OP_AUIPC;
                4: op = OP_JAL;
                5: op = OP_JALR;
                6: begin
                    op = OP_BRANCH;
                    if (f3[2:1] == 2'b01) f3[2] = 1'b1;
                end
                7: begin
                    op = OP_LOAD;
                    sub = $urandom_range(0, 4);
                    f3 = (sub < 3) ? 3'(sub) : 3'(sub + 1);
                end
                8: begin
                    op = OP_STORE;
                    f3 = 3'($urandom_range(0, 2));
                end
                default: begin
                    sub = $urandom_range(0, 3);
                    if (sub == 0) begin
                        op = 7'($urandom_range(0, 127));
                        for (int k = 0; k < 20 && is_legal(op); k++) op = 7'($urandom_range(0, 127));
                        if (is_legal(op)) op = 7'b0000000;
                    end else if (sub == 1) begin
                        op = OP_BRANCH;
                        f3 = 3'($urandom_range(2, 3));
                    end else if (sub == 2) begin
                        df = int'(TO) + 1 + $urandom_range(0, 2);
                    end else begin
                        op = OP_LOAD;
                        f3 = 3'b000;
                        dm = int'(TO) + 1;
                    end
                end
            endcase
            set_ir(op, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            build(df, dm, tr);
            play(100);
            if (tr) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
